// File: rtl/vram_fb.sv
// Tile framebuffer: 300 x 32-bit words, four big-endian 8-bit tiles per word.
// Three users share the RAM. The VGA port is a registered read that is always
// active. The CPU port does strobed word writes and registered word reads.
// The fill engine writes one word per cycle to clear or paint the screen.
module vram_fb #(
    parameter int unsigned WORDS = 300,
    parameter int unsigned AW    = 9
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [31:0]   i_vaddr,
    output logic [31:0]   o_vdata,
    input  logic [31:0]   i_cpu_addr,
    input  logic          i_cpu_we,
    input  logic [31:0]   i_cpu_wdata,
    input  logic [3:0]    i_cpu_wstrb,
    input  logic          i_cpu_re,
    output logic [31:0]   o_cpu_rdata,
    output logic          o_cpu_rvalid,
    output logic          o_cpu_ready,
    input  logic          i_fill_start,
    input  logic [7:0]    i_fill_color,
    output logic          o_busy,
    output logic          o_done
);

    localparam logic [AW-1:0] LastIdx = AW'(WORDS - 1);
    // VGA addresses are tile (byte) addresses; four tiles per word.
    localparam logic [31:0]   VLimit  = 32'(4 * WORDS);

    typedef enum logic {StIdle, StFill} state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic [7:0]    r_color, w_color_nxt;
    logic          r_done, w_done_nxt;

    logic [31:0]   r_mem [WORDS];
    logic [31:0]   r_vdata;
    logic [31:0]   r_cpu_rdata;
    logic          r_cpu_rvalid;

    logic [AW-1:0] w_cpu_idx;
    logic [AW-1:0] w_v_idx;
    logic          w_cpu_in_range;
    logic          w_v_in_range;
    logic          w_fill_we;
    logic          w_cpu_we;
    logic          w_cpu_re;
    logic          w_unused_cpu_addr;

    // CPU address bits outside the word index are don't-care.
    assign w_unused_cpu_addr = ^{i_cpu_addr[31:AW+2], i_cpu_addr[1:0]};

    assign w_cpu_idx      = i_cpu_addr[AW+1:2];
    assign w_cpu_in_range = {{(32 - AW){1'b0}}, w_cpu_idx} < WORDS;
    // Full-width compare so that aliasing high addresses still read as blank.
    assign w_v_in_range   = i_vaddr < VLimit;
    assign w_v_idx        = i_vaddr[AW+1:2];

    assign o_busy       = (r_state == StFill);
    assign o_cpu_ready  = (r_state == StIdle);
    assign o_done       = r_done;
    assign o_vdata      = r_vdata;
    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_cpu_rvalid = r_cpu_rvalid;

    assign w_fill_we = (r_state == StFill);
    assign w_cpu_we  = (r_state == StIdle) && i_cpu_we && w_cpu_in_range;
    assign w_cpu_re  = (r_state == StIdle) && i_cpu_re;

    // Fill engine next-state: idle waits for a start, fill walks idx to the last word.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_color_nxt = r_color;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_fill_start) begin
                    w_state_nxt = StFill;
                    w_idx_nxt   = '0;
                    w_color_nxt = i_fill_color;
                end
            end
            StFill: begin
                if (r_idx == LastIdx) begin
                    w_state_nxt = StIdle;
                    w_idx_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
        endcase
    end

    // Fill engine state; reset starts a clear to colour 0x00.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StFill;
            r_idx   <= '0;
            r_color <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_color <= w_color_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // RAM write port. Fill and CPU writes are exclusive by state. The RAM itself is not reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_fill_we) begin
                r_mem[r_idx] <= {4{r_color}};
            end else if (w_cpu_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_cpu_wstrb[b]) begin
                        r_mem[w_cpu_idx][8*b +: 8] <= i_cpu_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Registered reads. They sample pre-write contents, so a same-cycle write reads old data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vdata      <= '0;
            r_cpu_rdata  <= '0;
            r_cpu_rvalid <= 1'b0;
        end else begin
            r_vdata      <= w_v_in_range ? r_mem[w_v_idx] : 32'h0;
            r_cpu_rvalid <= w_cpu_re;
            if (w_cpu_re) begin
                r_cpu_rdata <= w_cpu_in_range ? r_mem[w_cpu_idx] : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_vram_fb.sv
// Scoreboard bench for vram_fb: stimulus queues expected read data, a monitor checks it.
module tb_vram_fb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] vaddr = '0;
    logic [31:0] vdata;
    logic [31:0] cpu_addr = '0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        cpu_ready;
    logic        fill_start = 1'b0;
    logic [7:0]  fill_color = '0;
    logic        busy;
    logic        done;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] rq[$];
    logic [31:0] vq[$];
    logic        vreq = 1'b0;
    logic        vchk = 1'b0;

    vram_fb #(.WORDS(300), .AW(9)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_vaddr      (vaddr),
        .o_vdata      (vdata),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_we     (cpu_we),
        .i_cpu_wdata  (cpu_wdata),
        .i_cpu_wstrb  (cpu_wstrb),
        .i_cpu_re     (cpu_re),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_rvalid (cpu_rvalid),
        .o_cpu_ready  (cpu_ready),
        .i_fill_start (fill_start),
        .i_fill_color (fill_color),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // VGA reads have no valid strobe; the bench delays its own request flag by one edge.
    always @(posedge clk) vchk <= vreq;

    // Monitor: pop and compare whenever the DUT presents read data.
    always @(negedge clk) begin
        logic [31:0] e;
        if (cpu_rvalid === 1'b1) begin
            if (rq.size() == 0) begin
                n_total++;
                $display("FAIL cpu_rvalid_unexpected: got rdata %h with no read pending", cpu_rdata);
            end else begin
                e = rq.pop_front();
                chk("cpu_rdata", cpu_rdata, e);
            end
        end
        if (vchk) begin
            if (vq.size() == 0) begin
                n_total++;
                $display("FAIL vga_queue_empty: got vdata %h with no expectation", vdata);
            end else begin
                e = vq.pop_front();
                chk("vdata", vdata, e);
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (cpu_ready !== 1'b1 && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 1000) chk("ready_timeout", {31'b0, cpu_ready}, 32'd1);
    endtask

    // One bus cycle of combined stimulus.
    task automatic op(input bit we, input bit re, input bit fs, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input logic [7:0] col,
                      input bit vr, input logic [31:0] va,
                      input logic [31:0] exp_r, input logic [31:0] exp_v);
        if (we || re || fs) wait_ready();
        cpu_we = we; cpu_re = re; fill_start = fs; cpu_addr = addr;
        cpu_wdata = wd; cpu_wstrb = st; fill_color = col; vreq = vr; vaddr = va;
        if (re) rq.push_back(exp_r);
        if (vr) vq.push_back(exp_v);
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_re = 1'b0; fill_start = 1'b0; vreq = 1'b0;
    endtask

    task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        op(1, 0, 0, a, d, s, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic cpu_rd(input logic [31:0] a, input logic [31:0] e);
        op(0, 1, 0, a, 0, 0, 8'h00, 0, 0, e, 0);
    endtask

    task automatic vga_rd(input logic [31:0] a, input logic [31:0] e);
        op(0, 0, 0, 0, 0, 0, 8'h00, 1, a, 0, e);
    endtask

    // Called right after the edge that enters FILL (cycle 0); done is due on cycle 300.
    task automatic wait_fill(input int poke_at, input int rst_at, input string tag);
        int cyc;
        bit seen;
        bit busy_ok;
        bit did_rst;
        cyc = 0; seen = 0; busy_ok = 1; did_rst = 0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            if (cyc == poke_at) begin
                // Everything here lands in FILL and must be ignored.
                fill_start = 1'b1; fill_color = 8'hAA;
                cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 32'd28;
                cpu_wdata = 32'h12345678; cpu_wstrb = 4'hF;
            end
            if (cyc == rst_at && !did_rst) rst = 1'b1;
            @(posedge clk); #1;
            fill_start = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0;
            if (rst) begin
                rst = 1'b0; did_rst = 1; cyc = 0;
                chk({tag, "_rst_busy"}, {31'b0, busy}, 32'd1);
                chk({tag, "_rst_ready"}, {31'b0, cpu_ready}, 32'd0);
                continue;
            end
            cyc++;
            if (done === 1'b1) seen = 1;
            else if (busy !== 1'b1) busy_ok = 0;
        end
        chk({tag, "_done_cycle"}, 32'(cyc), 32'd300);
        chk({tag, "_busy_held"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_idle_ready"}, {31'b0, cpu_ready}, 32'd1);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset: one edge, then the automatic clear.
        @(posedge clk); #1;
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_ready", {31'b0, cpu_ready}, 32'd0);
        chk("rst_vdata", vdata, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_rvalid", {31'b0, cpu_rvalid}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        wait_fill(-1, -1, "clear");
        for (int a = 0; a < 1200; a++) vga_rd(a, 32'h0);

        // Strobed write, CPU and VGA readback.
        cpu_wr(32'h10, 32'hA1B2C3D4, 4'b1010);
        cpu_rd(32'h10, 32'hA100C300);
        cpu_rd(32'h13, 32'hA100C300);
        for (int a = 16; a < 20; a++) vga_rd(a, 32'hA100C300);
        // Same-cycle write, CPU read and VGA read of one word all return old data.
        op(1, 1, 0, 32'h10, 32'h55555555, 4'hF, 8'h00, 1, 32'd17, 32'hA100C300, 32'hA100C300);
        cpu_rd(32'h10, 32'h55555555);
        vga_rd(32'd18, 32'h55555555);
        cpu_wr(32'h12, 32'h123456EE, 4'b0001);
        cpu_rd(32'h10, 32'h555555EE);
        repeat (3) @(posedge clk);
        #1;
        chk("rdata_hold", cpu_rdata, 32'h555555EE);
        chk("rvalid_pulse", {31'b0, cpu_rvalid}, 32'd0);

        // Fill 0x3C; a second start, a write and a read at cycle 100 are all ignored.
        op(0, 0, 1, 0, 0, 0, 8'h3C, 0, 0, 0, 0);
        wait_fill(100, -1, "fill3c");

        // Out-of-range accesses, then confirm every word still holds the fill.
        cpu_wr(32'd1200, 32'hDEADBEEF, 4'hF);
        cpu_rd(32'd1200, 32'h0);
        cpu_rd(32'h800, 32'h3C3C3C3C);
        vga_rd(32'd1200, 32'h0);
        vga_rd(32'h1000, 32'h0);
        vga_rd(32'd1199, 32'h3C3C3C3C);
        for (int w = 0; w < 300; w++) cpu_rd(32'(4 * w), 32'h3C3C3C3C);

        // CPU write and read with fill_start in the same cycle; the fill overwrites word 5.
        op(1, 1, 1, 32'd20, 32'hFFFFFFFF, 4'hF, 8'h00, 0, 0, 32'h3C3C3C3C, 0);
        wait_fill(-1, -1, "fill00");
        cpu_rd(32'd20, 32'h0);
        cpu_rd(32'd1196, 32'h0);

        // Reset in the middle of a 0x3C fill restarts it as a clear.
        op(0, 0, 1, 0, 0, 0, 8'h3C, 0, 0, 0, 0);
        wait_fill(-1, 150, "fillrst");
        for (int w = 0; w < 300; w++) cpu_rd(32'(4 * w), 32'h0);
        vga_rd(32'd0, 32'h0);
        vga_rd(32'd600, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("rq_drained", 32'(rq.size()), 32'd0);
        chk("vq_drained", 32'(vq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vram_fb.md
Name: vram_fb

Overview:
Framebuffer for the 40x30 character/tile VGA display: 300 x 32-bit words, four 8-bit tiles per word, stored big-endian (tile byte offset 0 = bits 31:24).
- Sits directly upstream of the VGA timing stage. It answers that stage's vaddr with registered vdata.
- It also exposes a CPU-side word read/write port with byte strobes.
- A hardware fill engine clears the screen, or paints it one colour, after reset and on request.

Parameters:
WORDS, 300, number of 32-bit words (40*30 tiles / 4).
AW, 9, word-index width (2**AW >= WORDS).

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
vaddr  in  32  VGA tile (byte) address = col + 40*row, range 0..1199
vdata  out  32  word containing tile vaddr, one cycle after vaddr
cpu_addr  in  32  CPU byte address; word index = cpu_addr[AW+1:2], bits [1:0] ignored
cpu_we  in  1  write request
cpu_wdata  in  32  write data
cpu_wstrb  in  4  byte enables; [3] = bits 31:24 (byte offset 0) ... [0] = bits 7:0
cpu_re  in  1  read request
cpu_rdata  out  32  read data
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
cpu_ready  out  1  high when CPU requests are accepted this cycle
fill_start  in  1  pulse: begin fill with fill_color
fill_color  in  8  tile value to replicate into all four bytes
busy  out  1  fill engine active
done  out  1  one-cycle pulse after last fill write

Behaviour:
- Storage: WORDS x 32 RAM, not reset; contents are defined only by the fill engine after reset.
- FSM states are IDLE and FILL; registers idx[AW-1:0] and color[7:0].
- Reset (rst=1 at an edge):
  - state<=FILL, idx<=0, color<=0x00.
  - vdata<=0, cpu_rdata<=0, cpu_rvalid<=0, done<=0.
  - busy=1 and cpu_ready=0 from the following cycle, so the screen is cleared automatically after reset.
- Reset mid-fill or mid-access: same as above; any in-progress fill restarts at idx 0 with colour 0x00.
- FILL state, each cycle:
  - Writes {color,color,color,color} to mem[idx].
  - If idx==WORDS-1: state<=IDLE, idx<=0, done<=1 for exactly one cycle. Otherwise idx<=idx+1.
  - A full fill takes exactly WORDS cycles.
- busy = (state==FILL); cpu_ready = (state==IDLE). Both are driven from the state register only.
- fill_start:
  - Sampled only in IDLE: state<=FILL, idx<=0, color<=fill_color.
  - Ignored in FILL; no restart and no colour change.
- CPU requests while cpu_ready=0 are ignored. The requester holds them until ready.
- CPU write (IDLE, cpu_we):
  - Each byte lane with its strobe set is written at word cpu_addr[AW+1:2].
  - Word index >= WORDS: write dropped silently.
- CPU read (IDLE, cpu_re):
  - At the next cycle, cpu_rdata = mem[word] and cpu_rvalid=1 for one cycle.
  - Out-of-range word returns 0. cpu_rdata holds its value until the next read.
- Simultaneous cpu_we and cpu_re to the same word: the read returns the old data (read-before-write).
- cpu_we/cpu_re together with fill_start in IDLE: the CPU access is performed that cycle; fill starts next cycle and overwrites the written word.
- VGA read port:
  - Always active, including during FILL; independent of the CPU port.
  - vdata(n+1) = mem[vaddr(n)>>2].
  - vaddr >= 4*WORDS (1200): vdata(n+1) = 0.
  - Same-cycle write and VGA read of one word: vdata returns the old data.
  - The one-cycle latency matches the VGA stage's registered display-enable.

Test Plan:
- Reset 1 cycle then release -> busy=1, cpu_ready=0 for 300 cycles; done pulses once on cycle 300; vaddr sweep 0..1199 then reads vdata=0x00000000 everywhere.
- Write addr=0x10, wdata=0xA1B2C3D4, wstrb=4'b1010 over word 0x00000000 -> CPU read addr 0x10 returns 0xA100C300 one cycle later with cpu_rvalid=1; vaddr=16..19 gives vdata=0xA100C300 next cycle.
- fill_start with fill_color=0x3C -> 300 busy cycles; all words read 0x3C3C3C3C; a second fill_start at cycle 100 of the fill is ignored (done still at cycle 300, colour 0x3C).
- In IDLE, cpu_we to word 5 (0xFFFFFFFF, wstrb=4'hF) with fill_start=1, fill_color=0x00 in the same cycle -> after done, word 5 reads 0x00000000.
- Out of range: write 0xDEADBEEF to addr 1200 -> no word changes; read addr 1200 -> 0; vaddr=1200 -> vdata=0.
- Assert rst at cycle 150 of a 0x3C fill -> fill restarts from idx 0 with 0x00; after done, all words read 0x00000000.
